// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues in-order imem requests, buffers responses for decode.
// Latency: imem response sampled at edge N is presented to decode right after edge N.
// Backpressure: credit-limited; outstanding + buffered <= FIFO_DEPTH, so requests stop when decode stalls.
//
// Ports:
//   clk, rst_n                     clock (rising edge), asynchronous active-low reset
//   if_jump_en_in/addr_in          redirect from execute (target bits [1:0] forced to 0)
//   imem_req_valid/ready/addr      fetch request handshake, addr = PC
//   imem_rsp_valid_in/data_in      in-order instruction responses, latency >= 1
//   if_instr_addr/instr/valid_out  instruction presented to decode
//   if_instr_ready_in              decode accepts presented instruction
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_jump_en_in,
  input  logic [31:0] if_jump_addr_in,
  output logic        imem_req_valid_out,
  input  logic        imem_req_ready_in,
  output logic [31:0] imem_req_addr_out,
  input  logic        imem_rsp_valid_in,
  input  logic [31:0] imem_rsp_data_in,
  output logic [31:0] if_instr_addr_out,
  output logic [31:0] if_instr_out,
  output logic        if_instr_valid_out,
  input  logic        if_instr_ready_in
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  // Pending-address queue: one entry per in-flight request, so its occupancy
  // is the outstanding-request count.
  logic [31:0]   pa_mem_q [FIFO_DEPTH];
  logic [31:0]   pa_mem_d [FIFO_DEPTH];
  logic [PW-1:0] pa_wptr_q, pa_wptr_d;
  logic [PW-1:0] pa_rptr_q, pa_rptr_d;
  logic [CW-1:0] pa_cnt_q, pa_cnt_d;

  // Output buffer holding {addr, instr} pairs for decode.
  logic [31:0]   of_addr_q [FIFO_DEPTH];
  logic [31:0]   of_addr_d [FIFO_DEPTH];
  logic [31:0]   of_data_q [FIFO_DEPTH];
  logic [31:0]   of_data_d [FIFO_DEPTH];
  logic [PW-1:0] of_wptr_q, of_wptr_d;
  logic [PW-1:0] of_rptr_q, of_rptr_d;
  logic [CW-1:0] of_cnt_q, of_cnt_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic [CW:0]   inflight;
  logic          credit_ok;
  logic          req_vld;
  logic          req_fire;
  logic          rsp_take;
  logic          rsp_drop;
  logic          of_vld;
  logic          of_pop;
  logic          of_push;
  logic [CW-1:0] outstanding_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight  = {1'b0, pa_cnt_q} + {1'b0, of_cnt_q};
    credit_ok = inflight < (CW+1)'(FIFO_DEPTH);
    // Gated by rst_n so no request is visible while reset is held.
    req_vld   = rst_n && (state_q == ST_RUN) && credit_ok;
    req_fire  = req_vld && imem_req_ready_in;
    // A response with nothing in flight is stale (pre-reset) and ignored.
    rsp_take  = imem_rsp_valid_in && (pa_cnt_q != '0);
    rsp_drop  = rsp_take && (drop_cnt_q != '0);
    of_vld    = (of_cnt_q != '0);
    of_pop    = of_vld && if_instr_ready_in;
    // A redirect wipes the buffer, so a response landing that cycle is lost too.
    of_push   = rsp_take && !rsp_drop && !if_jump_en_in;
    outstanding_nxt = pa_cnt_q + CW'(req_fire) - CW'(rsp_take);
  end

  // ---------------------------------------------------------------------------
  // PC / FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    state_d    = state_q;

    if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end

    if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
      if (drop_cnt_q == CW'(1)) begin
        state_d = ST_RUN;
      end
    end

    // Everything still in flight after this edge, including a request accepted
    // in the same cycle, belongs to the old path and must be discarded.
    if (if_jump_en_in) begin
      pc_d       = if_jump_addr_in & ~32'h3;
      drop_cnt_d = outstanding_nxt;
      state_d    = (outstanding_nxt != '0) ? ST_FLUSH : ST_RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-address queue next state
  // ---------------------------------------------------------------------------
  always_comb begin
    pa_mem_d  = pa_mem_q;
    pa_wptr_d = pa_wptr_q;
    pa_rptr_d = pa_rptr_q;
    pa_cnt_d  = outstanding_nxt;

    if (req_fire) begin
      pa_mem_d[pa_wptr_q] = pc_q;
      pa_wptr_d           = ptr_inc(pa_wptr_q);
    end
    if (rsp_take) begin
      pa_rptr_d = ptr_inc(pa_rptr_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    of_addr_d = of_addr_q;
    of_data_d = of_data_q;
    of_wptr_d = of_wptr_q;
    of_rptr_d = of_rptr_q;
    of_cnt_d  = of_cnt_q;

    if (if_jump_en_in) begin
      of_wptr_d = '0;
      of_rptr_d = '0;
      of_cnt_d  = '0;
    end else begin
      // Push while full is only possible together with a pop; the credit
      // rule keeps the buffer from ever overflowing.
      if (of_push) begin
        of_addr_d[of_wptr_q] = pa_mem_q[pa_rptr_q];
        of_data_d[of_wptr_q] = imem_rsp_data_in;
        of_wptr_d            = ptr_inc(of_wptr_q);
      end
      if (of_pop) begin
        of_rptr_d = ptr_inc(of_rptr_q);
      end
      of_cnt_d = of_cnt_q + CW'(of_push) - CW'(of_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
      pa_wptr_q  <= '0;
      pa_rptr_q  <= '0;
      pa_cnt_q   <= '0;
      of_wptr_q  <= '0;
      of_rptr_q  <= '0;
      of_cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pa_mem_q[i]  <= '0;
        of_addr_q[i] <= '0;
        of_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
      pa_wptr_q  <= pa_wptr_d;
      pa_rptr_q  <= pa_rptr_d;
      pa_cnt_q   <= pa_cnt_d;
      of_wptr_q  <= of_wptr_d;
      of_rptr_q  <= of_rptr_d;
      of_cnt_q   <= of_cnt_d;
      pa_mem_q   <= pa_mem_d;
      of_addr_q  <= of_addr_d;
      of_data_q  <= of_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_req_valid_out = req_vld;
  assign imem_req_addr_out  = pc_q;
  assign if_instr_valid_out = of_vld;
  // Data lines read zero while nothing is presented.
  assign if_instr_addr_out  = of_vld ? of_addr_q[of_rptr_q] : 32'd0;
  assign if_instr_out       = of_vld ? of_data_q[of_rptr_q] : 32'd0;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_jump_en_in;
  logic [31:0] if_jump_addr_in;
  logic        imem_req_valid_out;
  logic        imem_req_ready_in;
  logic [31:0] imem_req_addr_out;
  logic        imem_rsp_valid_in;
  logic [31:0] imem_rsp_data_in;
  logic [31:0] if_instr_addr_out;
  logic [31:0] if_instr_out;
  logic        if_instr_valid_out;
  logic        if_instr_ready_in;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .if_jump_en_in     (if_jump_en_in),
    .if_jump_addr_in   (if_jump_addr_in),
    .imem_req_valid_out(imem_req_valid_out),
    .imem_req_ready_in (imem_req_ready_in),
    .imem_req_addr_out (imem_req_addr_out),
    .imem_rsp_valid_in (imem_rsp_valid_in),
    .imem_rsp_data_in  (imem_rsp_data_in),
    .if_instr_addr_out (if_instr_addr_out),
    .if_instr_out      (if_instr_out),
    .if_instr_valid_out(if_instr_valid_out),
    .if_instr_ready_in (if_instr_ready_in)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_req = 0;
  int          n_dec = 0;
  logic [31:0] exp_req;
  logic [31:0] exp_dec;
  logic        found;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: sample handshakes at the falling edge, let the rising edge pass,
  // then score the handshakes and drive the imem model for the next edge.
  task automatic tick();
    logic        rf, sf, df, jf;
    logic [31:0] ra, da, dd;
    @(negedge clk);
    rf = imem_req_valid_out && imem_req_ready_in;
    ra = imem_req_addr_out;
    sf = imem_rsp_valid_in;
    df = if_instr_valid_out && if_instr_ready_in;
    da = if_instr_addr_out;
    dd = if_instr_out;
    jf = if_jump_en_in;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      mem_q.delete();
    end else begin
      if (sf && mem_q.size() != 0) mem_q.delete(0);
      if (rf) begin
        chk("req_addr", ra, exp_req);
        exp_req += 32'd4;
        n_req++;
        mem_q.push_back('{ra, cyc + lat});
      end
    end
    // A decode handshake coincident with a redirect is wrong-path by definition.
    if (df && !jf) begin
      chk("dec_addr", da, exp_dec);
      chk("dec_instr", dd, word_of(exp_dec));
      exp_dec += 32'd4;
      n_dec++;
    end
    if (mem_q.size() != 0 && mem_q[0].due <= cyc + 1) begin
      imem_rsp_valid_in = 1'b1;
      imem_rsp_data_in  = word_of(mem_q[0].addr);
    end else begin
      imem_rsp_valid_in = 1'b0;
      imem_rsp_data_in  = 32'd0;
    end
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    if_jump_en_in     = 1'b0;
    if_jump_addr_in   = 32'd0;
    imem_req_ready_in = 1'b1;
    imem_rsp_valid_in = 1'b0;
    imem_rsp_data_in  = 32'd0;
    if_instr_ready_in = 1'b1;
    exp_req           = RST_PC;
    exp_dec           = RST_PC;

    // Reset state
    tick();
    tick();
    chk("rst_req_valid", {31'd0, imem_req_valid_out}, 32'd0);
    chk("rst_instr_valid", {31'd0, if_instr_valid_out}, 32'd0);
    chk("rst_instr_addr", if_instr_addr_out, 32'd0);
    chk("rst_instr", if_instr_out, 32'd0);

    // Streaming fetch, latency 1, everything ready
    rst_n = 1'b1;
    #1;
    chk("first_req_valid", {31'd0, imem_req_valid_out}, 32'd1);
    chk("first_req_addr", imem_req_addr_out, RST_PC);
    tick();
    chk("valid_after_1", {31'd0, if_instr_valid_out}, 32'd0);
    tick();
    chk("valid_after_2", {31'd0, if_instr_valid_out}, 32'd1);
    chk("first_dec_addr", if_instr_addr_out, RST_PC);
    chk("first_dec_instr", if_instr_out, word_of(RST_PC));
    for (int i = 0; i < 12; i++) tick();
    chk("stream_n_dec", n_dec, 32'd8);
    chk("stream_n_req", n_req, 32'd10);

    // Decode stall for 5 cycles
    if_instr_ready_in = 1'b0;
    tick();
    chk("stall_req_valid", {31'd0, imem_req_valid_out}, 32'd0);
    chk("stall_addr_a", if_instr_addr_out, 32'h8000_0020);
    for (int i = 0; i < 4; i++) tick();
    chk("stall_valid", {31'd0, if_instr_valid_out}, 32'd1);
    chk("stall_req_valid_b", {31'd0, imem_req_valid_out}, 32'd0);
    chk("stall_addr_b", if_instr_addr_out, 32'h8000_0020);
    chk("stall_instr_b", if_instr_out, word_of(32'h8000_0020));
    if_instr_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("after_stall_n_dec", n_dec, 32'd14);

    // imem not ready for 4 cycles: address held, no extra requests
    imem_req_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_req_valid", {31'd0, imem_req_valid_out}, 32'd1);
      chk("hold_req_addr", imem_req_addr_out, 32'h8000_003C);
    end
    chk("hold_n_req", n_req, 32'd15);

    // Latency 3, two outstanding, redirect to 0x100
    lat = 3;
    imem_req_ready_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_q.size() == 2 && !imem_rsp_valid_in) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_two_outstanding", {31'd0, found}, 32'd1);
    if_jump_en_in   = 1'b1;
    if_jump_addr_in = 32'h0000_0100;
    tick();
    if_jump_en_in = 1'b0;
    exp_req = 32'h0000_0100;
    exp_dec = 32'h0000_0100;
    chk("flush_req_valid_0", {31'd0, imem_req_valid_out}, 32'd0);
    chk("flush_instr_valid_0", {31'd0, if_instr_valid_out}, 32'd0);
    tick();
    chk("flush_req_valid_1", {31'd0, imem_req_valid_out}, 32'd0);
    tick();
    chk("post_flush_req_valid", {31'd0, imem_req_valid_out}, 32'd1);
    chk("post_flush_req_addr", imem_req_addr_out, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (if_instr_valid_out) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_dec_0x100", {31'd0, found}, 32'd1);
    chk("dec_after_jump", if_instr_addr_out, 32'h0000_0100);

    // Redirect to 0x203 together with a response and a decode handshake
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_rsp_valid_in && if_instr_valid_out && if_instr_ready_in) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_rsp_and_dec", {31'd0, found}, 32'd1);
    if_jump_en_in   = 1'b1;
    if_jump_addr_in = 32'h0000_0203;
    tick();
    if_jump_en_in = 1'b0;
    exp_req = 32'h0000_0200;
    exp_dec = 32'h0000_0200;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid_out) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_req_0x200", {31'd0, found}, 32'd1);
    chk("req_after_jump_203", imem_req_addr_out, 32'h0000_0200);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (if_instr_valid_out) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_dec_0x200", {31'd0, found}, 32'd1);
    chk("dec_after_jump_203", if_instr_addr_out, 32'h0000_0200);
    chk("dec_instr_0x200", if_instr_out, word_of(32'h0000_0200));

    // Reset asserted in the middle of a flush
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_q.size() != 0 && !imem_rsp_valid_in) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_inflight", {31'd0, found}, 32'd1);
    if_jump_en_in   = 1'b1;
    if_jump_addr_in = 32'h0000_0400;
    tick();
    if_jump_en_in = 1'b0;
    chk("mid_flush_req_valid", {31'd0, imem_req_valid_out}, 32'd0);
    rst_n = 1'b0;
    mem_q.delete();
    imem_rsp_valid_in = 1'b0;
    imem_rsp_data_in  = 32'd0;
    #1;
    chk("async_rst_req_valid", {31'd0, imem_req_valid_out}, 32'd0);
    chk("async_rst_instr_valid", {31'd0, if_instr_valid_out}, 32'd0);
    chk("async_rst_instr_addr", if_instr_addr_out, 32'd0);
    chk("async_rst_instr", if_instr_out, 32'd0);
    tick();
    tick();
    exp_req = RST_PC;
    exp_dec = RST_PC;
    lat = 1;
    rst_n = 1'b1;
    #1;
    chk("rerst_req_valid", {31'd0, imem_req_valid_out}, 32'd1);
    chk("rerst_req_addr", imem_req_addr_out, RST_PC);
    tick();
    tick();
    chk("rerst_dec_valid", {31'd0, if_instr_valid_out}, 32'd1);
    chk("rerst_dec_addr", if_instr_addr_out, RST_PC);
    for (int i = 0; i < 4; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
